cout_logger: RTL and testbench
==============================

COUT_LOGGER -- requirements
Module: cout_logger

Interface
REQ-001 Parameter: DEPTH, 4, event FIFO entries (power of 2, 2..16).
REQ-002 Parameter: WRAP_W, 8, width of net wrap counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 CLK  input  1  rising-edge clock, same clock as the 4-bit up/down counter.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 CLR  input  1  synchronous clear of FIFO, wrap counter and OVF.
REQ-007 COUT  input  1  counter carry/borrow flag, level-sampled each cycle.
REQ-008 DOUT  input  4  counter value, sampled with COUT.
REQ-009 UD  input  1  counter direction (1 = up, 0 = down), sampled with COUT.
REQ-010 EVT_VALID  output  1  FIFO head holds an event.
REQ-011 EVT_READY  input  1  consumer accepts head when EVT_VALID=1.
REQ-012 EVT_DATA  output  5  head event {UD, DOUT}.
REQ-013 WRAPS  output  WRAP_W  signed (two's complement) net wrap count.
REQ-014 FULL  output  1  FIFO holds DEPTH entries.
REQ-015 OVF  output  1  sticky: an event was dropped.

Function
REQ-016 Push: each rising CLK edge with COUT=1 SHALL produce one event {UD, DOUT} captured from that edge's sampled inputs; consecutive COUT=1 cycles give one event per cycle.
REQ-017 Pop: the head SHALL be removed on a rising edge when EVT_VALID=1 and EVT_READY=1; EVT_READY with EVT_VALID=0 has no effect.
REQ-018 Latency: a pushed event into an empty FIFO SHALL appear on EVT_VALID/EVT_DATA exactly one cycle after the sampling edge; there is no combinational input-to-output path.
REQ-019 EVT_DATA SHALL hold stable while EVT_VALID=1 and EVT_READY=0.
REQ-020 Ordering SHALL be strict FIFO.
REQ-021 Push while full without simultaneous pop: event dropped, contents unchanged, OVF set to 1 next cycle.
REQ-022 Push while full with simultaneous pop: both occur, occupancy stays DEPTH, OVF unchanged.
REQ-023 Push and pop on same edge at any non-full occupancy: occupancy unchanged, new event enqueued behind remaining entries.
REQ-024 FULL SHALL be 1 iff occupancy == DEPTH; EVT_VALID SHALL be 1 iff occupancy > 0; both are registered.
REQ-025 WRAPS SHALL add 1 on COUT=1 with UD=1 and subtract 1 on COUT=1 with UD=0, modulo 2^WRAP_W (0x7F+1 -> 0x80, 0x00-1 -> 0xFF at WRAP_W=8), updated even when the event is dropped.
REQ-026 CLR=1 SHALL, on that edge, empty the FIFO, zero WRAPS, clear OVF, and ignore any COUT on the same edge; CLR has priority over push/pop.
REQ-027 OVF SHALL stay 1 until CLR or reset.

Reset
REQ-028 RST_N=0 SHALL immediately, independent of CLK, force EVT_VALID=0, FULL=0, OVF=0, WRAPS=0, EVT_DATA=0, and FIFO pointers to 0.
REQ-029 While RST_N=0, COUT, CLR and EVT_READY SHALL be ignored; the first active edge is the first edge after RST_N rises.
REQ-030 Reset asserted mid-operation SHALL discard all stored events with no partial state retained.

Verification
REQ-031 Reset, then COUT=1, UD=1, DOUT=4'hF for 1 cycle, EVT_READY=0 -> next cycle EVT_VALID=1, EVT_DATA=5'h1F, WRAPS=1.
REQ-032 EVT_READY=0, 5 consecutive COUT=1 pulses (DOUT 1..5, UD=0) with DEPTH=4 -> FULL=1 after 4th, OVF=1 after 5th, WRAPS=0xFB; draining yields DOUT 1,2,3,4 in order.
REQ-033 FIFO full, COUT=1 and EVT_READY=1 on same edge -> head popped, new event appended, FULL stays 1, OVF stays 0.
REQ-034 WRAPS=0x7F, one up event -> WRAPS=0x80; WRAPS=0x00, one down event -> WRAPS=0xFF.
REQ-035 3 events stored, OVF=1, CLR=1 with COUT=1 on same edge -> next cycle EVT_VALID=0, WRAPS=0, OVF=0, no event logged.
REQ-036 RST_N pulled low between clock edges with 2 events stored -> EVT_VALID, FULL, OVF, WRAPS read 0 before the next CLK edge.

Source files
------------

// File: rtl/cout_logger.sv
// Event logger for a 4-bit up/down counter: queues {UD, DOUT} on every COUT
// and keeps a signed net wrap count plus a sticky overflow flag.
module cout_logger #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic              COUT,
  input  logic [3:0]        DOUT,
  input  logic              UD,
  output logic              EVT_VALID,
  input  logic              EVT_READY,
  output logic [4:0]        EVT_DATA,
  output logic [WRAP_W-1:0] WRAPS,
  output logic              FULL,
  output logic              OVF
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              valid_q;
  logic              full_q;
  logic              ovf_q;
  logic [WRAP_W-1:0] wraps_q;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              drop;

  always_comb begin
    push  = COUT & ~CLR;
    pop   = valid_q & EVT_READY & ~CLR;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    wr_en = push & (~full_q | pop);
    drop  = push & full_q & ~pop;
    cnt_d = cnt_q;
    if (wr_en && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !wr_en) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wraps_q  <= '0;
    end else if (CLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wraps_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {UD, DOUT};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      full_q  <= (cnt_d == CW'(DEPTH));
      if (drop) begin
        ovf_q <= 1'b1;
      end
      // Wrap count tracks every carry/borrow, including dropped events.
      if (COUT) begin
        wraps_q <= UD ? wraps_q + WRAP_W'(1) : wraps_q - WRAP_W'(1);
      end
    end
  end

  assign EVT_VALID = valid_q;
  assign EVT_DATA  = mem_q[rd_ptr_q];
  assign WRAPS     = wraps_q;
  assign FULL      = full_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_cout_logger.sv
// Self-checking bench for cout_logger: directed scenarios plus random traffic,
// checked every edge against a queue-based reference model.
module tb_cout_logger;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned WRAP_W = 8;

  logic              CLK       = 1'b0;
  logic              RST_N     = 1'b1;
  logic              CLR       = 1'b0;
  logic              COUT      = 1'b0;
  logic [3:0]        DOUT      = 4'h0;
  logic              UD        = 1'b0;
  logic              EVT_READY = 1'b0;
  logic              EVT_VALID;
  logic [4:0]        EVT_DATA;
  logic [WRAP_W-1:0] WRAPS;
  logic              FULL;
  logic              OVF;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0]        exp_q[$];
  logic [WRAP_W-1:0] m_wraps = '0;
  logic              m_ovf   = 1'b0;

  cout_logger #(
    .DEPTH  (DEPTH),
    .WRAP_W (WRAP_W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CLR       (CLR),
    .COUT      (COUT),
    .DOUT      (DOUT),
    .UD        (UD),
    .EVT_VALID (EVT_VALID),
    .EVT_READY (EVT_READY),
    .EVT_DATA  (EVT_DATA),
    .WRAPS     (WRAPS),
    .FULL      (FULL),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard/monitor: outputs seen just before each edge must match the model
  // state built from all earlier edges; the model then absorbs this edge.
  initial begin : monitor
    forever begin
      @(posedge CLK);
      if (!RST_N) begin
        check("rst_evt_valid", 32'(EVT_VALID), 32'd0);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_ovf", 32'(OVF), 32'd0);
        check("rst_wraps", 32'(WRAPS), 32'd0);
        check("rst_evt_data", 32'(EVT_DATA), 32'd0);
        exp_q.delete();
        m_wraps = '0;
        m_ovf   = 1'b0;
      end else begin
        check("evt_valid", 32'(EVT_VALID), 32'(exp_q.size() > 0));
        check("full", 32'(FULL), 32'(exp_q.size() == int'(DEPTH)));
        check("ovf", 32'(OVF), 32'(m_ovf));
        check("wraps", 32'(WRAPS), 32'(m_wraps));
        if (exp_q.size() > 0) begin
          check("evt_data", 32'(EVT_DATA), 32'(exp_q[0]));
        end
        if (CLR) begin
          exp_q.delete();
          m_wraps = '0;
          m_ovf   = 1'b0;
        end else begin
          if (exp_q.size() > 0 && EVT_READY) begin
            void'(exp_q.pop_front());
          end
          if (COUT) begin
            m_wraps = UD ? m_wraps + WRAP_W'(1) : m_wraps - WRAP_W'(1);
            if (exp_q.size() < int'(DEPTH)) begin
              exp_q.push_back({UD, DOUT});
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
      end
    end
  end

  // One call = one clock cycle of input values, applied on the falling edge.
  task automatic drive(input logic cout, input logic ud, input logic [3:0] d,
                       input logic rdy, input logic clr);
    @(negedge CLK);
    COUT      = cout;
    UD        = ud;
    DOUT      = d;
    EVT_READY = rdy;
    CLR       = clr;
  endtask

  initial begin : stimulus
    #1 RST_N = 1'b0;
    // Activity during reset must be ignored.
    repeat (2) drive(1'b1, 1'b1, 4'hA, 1'b1, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;
    COUT = 1'b0; CLR = 1'b0; EVT_READY = 1'b0;

    // Single up event with DOUT=F.
    drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Five down events into a 4-deep FIFO, then drain.
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (6) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Full FIFO with simultaneous push and pop.
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'(i + 8), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'hC, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (6) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Signed wrap boundaries: 0x7F -> 0x80 and 0x00 -> 0xFF.
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    repeat (127) drive(1'b1, 1'b1, 4'($urandom), 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'h5, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 4'h3, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Three stored, OVF set, then CLR together with COUT.
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 4'(i), 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
            $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset between edges with two events stored.
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    COUT = 1'b1; EVT_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    COUT = 1'b0; EVT_READY = 1'b0;
    drive(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
